// File: rtl/fpu_bus_initiator_if.sv
// rtl/fpu_bus_initiator_if.sv - command/response and peripheral bus bundle for fpu_bus_initiator
interface fpu_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_err;
    logic [5:0]  p_address;
    logic [31:0] p_wdata;
    logic [1:0]  p_data_write_n;
    logic [1:0]  p_data_read_n;
    logic [31:0] p_rdata;
    logic        p_data_ready;

    // master: the initiator block itself; slave: command source, response sink and peripheral
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, p_rdata, p_data_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_err,
               p_address, p_wdata, p_data_write_n, p_data_read_n
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, p_rdata, p_data_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_err,
               p_address, p_wdata, p_data_write_n, p_data_read_n
    );
endinterface

// File: rtl/fpu_bus_initiator.sv
// rtl/fpu_bus_initiator.sv - drives one half-float op through a peripheral FPU: write A, write B, poll ready, read result
module fpu_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [5:0]  RESULT_ADDR    = 6'h0C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_bus_initiator_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WAIT,
        S_RD,
        S_RESP
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  ERR_OK   = 2'b00;
    localparam logic [1:0]  ERR_TMO  = 2'b01;
    localparam logic [1:0]  ERR_OP   = 2'b10;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic [1:0]  err_q, err_d;

    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus.p_rdata[31:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            cnt_q    <= 16'd0;
            result_q <= 16'd0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = bus.cmd_op;
                    a_d  = bus.cmd_a;
                    b_d  = bus.cmd_b;
                    // invalid ops are answered without touching the peripheral
                    if (bus.cmd_op > 3'd2) begin
                        result_d = 16'd0;
                        err_d    = ERR_OP;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WR_A;
                    end
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ready takes priority over a coincident timeout
                if (bus.p_data_ready) begin
                    state_d = S_RD;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = 16'd0;
                    err_d    = ERR_TMO;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RD: begin
                result_d = bus.p_rdata[15:0];
                err_d    = ERR_OK;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.rsp_result     = result_q;
        bus.rsp_err        = err_q;
        bus.p_address      = 6'd0;
        bus.p_wdata        = 32'd0;
        bus.p_data_write_n = 2'b11;
        bus.p_data_read_n  = 2'b11;
        case (state_q)
            // gated by rst_n so no command is offered while reset is held
            S_IDLE: bus.cmd_ready = rst_n;
            S_WR_A: begin
                bus.p_address      = {1'b0, op_q, 2'b00};
                bus.p_wdata        = {16'h0, a_q};
                bus.p_data_write_n = 2'b01;
            end
            S_WR_B: begin
                bus.p_address      = {1'b0, op_q, 2'b01};
                bus.p_wdata        = {16'h0, b_q};
                bus.p_data_write_n = 2'b01;
            end
            S_RD: begin
                bus.p_address     = RESULT_ADDR;
                bus.p_data_read_n = 2'b01;
            end
            S_RESP:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpu_bus_initiator.sv
// tb/tb_fpu_bus_initiator.sv - randomized and directed bench for fpu_bus_initiator against a timeline reference model
module tb_fpu_bus_initiator;

    localparam int unsigned TMO  = 8;
    localparam logic [5:0]  RADR = 6'h0C;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    logic [15:0] rd_res;
    logic [15:0] rd_hi;

    fpu_bus_initiator_if bus ();

    fpu_bus_initiator #(
        .TIMEOUT_CYCLES (TMO),
        .RESULT_ADDR    (RADR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.p_rdata = (bus.p_address == RADR) ? {rd_hi, rd_res} : {rd_hi, ~rd_res};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] bus_snapshot();
        return {20'd0, bus.cmd_ready, bus.rsp_valid, bus.p_data_write_n, bus.p_data_read_n,
                bus.p_address, bus.p_wdata};
    endfunction

    function automatic logic [63:0] bus_expect(input bit crdy, input bit rvld, input bit wr,
                                               input bit rd, input logic [5:0] adr,
                                               input logic [31:0] wd);
        return {20'd0, crdy, rvld, (wr ? 2'b01 : 2'b11), (rd ? 2'b01 : 2'b11), adr, wd};
    endfunction

    // One full transaction. d: cycles after WR_B at which the peripheral raises ready (0 = never).
    // bp: cycles rsp_ready is withheld once the response appears. stale: ready held high through WR_A.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int d, input logic [15:0] res,
                           input int bp, input bit stale);
        bit          bad;
        bit          tmo;
        int          v;
        logic [15:0] exp_res;
        logic [1:0]  exp_err;
        bit          e_idle, e_resp, e_wra, e_wrb, e_rd;
        logic [5:0]  e_adr;
        logic [31:0] e_wd;

        bad = (op > 3'd2);
        tmo = !bad && (d == 0 || d > int'(TMO));
        if (bad)      begin v = 1;       exp_res = 16'h0; exp_err = 2'b10; end
        else if (tmo) begin v = 3 + TMO; exp_res = 16'h0; exp_err = 2'b01; end
        else          begin v = d + 4;   exp_res = res;   exp_err = 2'b00; end

        rd_res = res;
        rd_hi  = 16'($urandom);
        @(negedge clk);
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_a        = a;
        bus.cmd_b        = b;
        bus.rsp_ready    = 1'b0;
        bus.p_data_ready = stale;
        check({tag, ".accept"}, {63'd0, bus.cmd_ready}, 64'd1);

        for (int t = 1; t <= v + bp + 1; t++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            e_idle = (t > v + bp);
            e_resp = !e_idle && (t >= v);
            e_wra  = !bad && t == 1;
            e_wrb  = !bad && t == 2;
            e_rd   = !bad && !tmo && t == v - 1;
            e_adr  = e_wra ? {1'b0, op, 2'b00} : e_wrb ? {1'b0, op, 2'b01} : e_rd ? RADR : 6'd0;
            e_wd   = e_wra ? {16'h0, a} : e_wrb ? {16'h0, b} : 32'd0;
            check({tag, ".bus"}, bus_snapshot(), bus_expect(e_idle, e_resp, e_wra || e_wrb, e_rd, e_adr, e_wd));
            if (e_resp) check({tag, ".rsp"}, {46'd0, bus.rsp_err, bus.rsp_result}, {46'd0, exp_err, exp_res});
            bus.p_data_ready = (stale && t <= 1) || (d != 0 && t >= 2 + d);
            bus.rsp_ready    = (t >= v + bp);
        end
        bus.rsp_ready    = 1'b0;
        bus.p_data_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 3'd0;
        bus.cmd_a        = 16'd0;
        bus.cmd_b        = 16'd0;
        bus.rsp_ready    = 1'b0;
        bus.p_data_ready = 1'b0;
        rd_res           = 16'd0;
        rd_hi            = 16'd0;

        repeat (2) @(negedge clk);
        check("reset.bus", bus_snapshot(), bus_expect(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0));
        check("reset.rsp", {46'd0, bus.rsp_err, bus.rsp_result}, 64'd0);
        rst_n = 1'b1;
        #1 check("reset.release_ready", {63'd0, bus.cmd_ready}, 64'd1);

        run_cmd("add",      3'd0, 16'h3C00, 16'h3C00, 3, 16'h4000, 0, 1'b0);
        run_cmd("mult_bp",  3'd2, 16'h4000, 16'h4200, 2, 16'h4600, 5, 1'b0);
        run_cmd("timeout",  3'd1, 16'h1234, 16'h5678, 0, 16'hBEEF, 0, 1'b0);
        run_cmd("after_to", 3'd0, 16'h1111, 16'h2222, 1, 16'h3333, 1, 1'b0);
        run_cmd("badop",    3'd5, 16'hAAAA, 16'h5555, 1, 16'h7777, 2, 1'b0);
        run_cmd("badop7",   3'd7, 16'h0001, 16'h0002, 0, 16'h0000, 0, 1'b0);
        run_cmd("edge_rdy", 3'd1, 16'h0F0F, 16'hF0F0, int'(TMO),     16'hC0DE, 0, 1'b0);
        run_cmd("edge_tmo", 3'd2, 16'h0F0F, 16'hF0F0, int'(TMO) + 1, 16'hC0DE, 0, 1'b0);
        run_cmd("stale",    3'd0, 16'h3800, 16'h3800, 4, 16'h3C00, 0, 1'b1);

        // reset pulsed in the second WAIT cycle aborts silently
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd1;
        bus.cmd_a     = 16'h4400;
        bus.cmd_b     = 16'h3C00;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_wait.bus", bus_snapshot(), bus_expect(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_wait.ready", {62'd0, bus.cmd_ready, bus.rsp_valid}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_wait.no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        run_cmd("post_rst", 3'd1, 16'h4400, 16'h3C00, 2, 16'h4000, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_cmd("rand", op, 16'($urandom), 16'($urandom), int'($urandom_range(0, TMO + 3)),
                    16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_bus_initiator.md
FPU_BUS_INITIATOR -- requirements
Module: fpu_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before an operation is aborted.
REQ-002 SHALL have parameter RESULT_ADDR, default 6'h0C: peripheral result register address.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk and rst_n.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  a command is offered.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 cmd_op  input  3  operation: 0 add, 1 sub, 2 mult; 3-7 invalid.
REQ-009 cmd_a, cmd_b  input  16 each  half-precision operands.
REQ-010 rsp_valid  output  1  response held until accepted.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_result  output  16  result half-float.
REQ-013 rsp_err  output  2  status: 00 ok, 01 timeout, 10 bad op.
REQ-014 p_address  output  6  peripheral address.
REQ-015 p_wdata  output  32  peripheral write data.
REQ-016 p_data_write_n  output  2  write strobe: 11 idle, 01 halfword.
REQ-017 p_data_read_n  output  2  read strobe: 11 idle, 01 halfword.
REQ-018 p_rdata  input  32  peripheral read data, combinational from p_address.
REQ-019 p_data_ready  input  1  peripheral result-ready flag.

Function
REQ-020 States SHALL be: IDLE, WR_A, WR_B, WAIT, RD, RESP.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid=1 and cmd_ready=1, latching cmd_op, cmd_a and cmd_b.
REQ-022 Accepted command with op>2: SHALL go straight to RESP with rsp_err=10 and rsp_result=0, with no bus activity.
REQ-023 Accepted command with a valid op: SHALL go to WR_A.
REQ-024 WR_A (exactly 1 cycle): p_address={1'b0,op,2'b00}, p_wdata={16'h0,a}, p_data_write_n=01.
REQ-025 WR_B (exactly 1 cycle): p_address={1'b0,op,2'b01}, p_wdata={16'h0,b}, p_data_write_n=01.
REQ-026 WAIT: strobes SHALL be 11; p_data_ready SHALL be sampled every cycle; a 16-bit timeout counter is cleared on entry and increments once per WAIT cycle.
REQ-027 WAIT exit on p_data_ready=1: SHALL go to RD.
REQ-028 WAIT exit when the counter reaches TIMEOUT_CYCLES-1 with p_data_ready=0: SHALL go to RESP with rsp_err=01 and rsp_result=0.
REQ-029 If p_data_ready=1 on the timeout cycle, ready SHALL win: the block goes to RD.
REQ-030 RD (exactly 1 cycle): p_address=RESULT_ADDR, p_data_read_n=01; p_rdata[15:0] SHALL be captured into rsp_result at the end of the cycle, with rsp_err=00.
REQ-031 RESP: rsp_valid=1, with rsp_result and rsp_err held stable; on rsp_ready=1 SHALL return to IDLE in the next cycle.
REQ-032 rsp_valid and cmd_ready SHALL never both be 1; a new command SHALL NOT be accepted before the prior response is consumed.
REQ-033 Outside WR_A, WR_B and RD, strobes SHALL be 11, p_address SHALL be 0 and p_wdata SHALL be 0.
REQ-034 Latency, with acceptance at cycle 0: WR_A at cycle 1, WR_B at cycle 2, WAIT from cycle 3; if ready is first seen at cycle n, RD is at n+1 and rsp_valid rises at n+2.
REQ-035 Stale p_data_ready=1 during IDLE or WR_A SHALL be ignored; it is sampled only in WAIT.
REQ-036 After a timeout the peripheral state is undefined; recovery is by system reset only, and the block SHALL still accept the next command.

Reset
REQ-037 rst_n=0 SHALL, asynchronously, force state=IDLE, cmd_ready=0 while asserted, rsp_valid=0, rsp_result=0, rsp_err=00, strobes=11, p_address=0, p_wdata=0 and counter=0.
REQ-038 Reset mid-operation (any state) SHALL abort with no response; cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-039 Add: op=0, a=16'h3C00, b=16'h3C00, model raises ready 3 cycles after WR_B and returns 16'h4000 -> write addr 00 then 01, read addr 0C, rsp_result=16'h4000, rsp_err=00, rsp_valid at cycle 7.
REQ-040 Mult with backpressure: op=2, a=16'h4000, b=16'h4200, model returns 16'h4600, rsp_ready held 0 for 5 cycles -> writes to addr 08 and 09; response stable for 5 cycles; cmd_ready stays 0 until 1 cycle after rsp_ready=1.
REQ-041 Timeout: TIMEOUT_CYCLES=8, model never raises ready -> exactly 8 WAIT cycles, rsp_err=01, rsp_result=0, no read strobe.
REQ-042 Bad op: op=5 -> no write or read strobe; rsp_valid in the cycle after acceptance with rsp_err=10.
REQ-043 Reset in WAIT: rst_n pulsed low in the 2nd WAIT cycle -> strobes 11 immediately; no rsp_valid; a new command after release completes normally.
REQ-044 Stale ready: p_data_ready held 1 from the previous operation through WR_A, cleared by the model on the write to A -> no early RD; response carries the new result.
